// File: rtl/wb2axi_pkg.sv
// Shared AXI encodings and helpers for the Wishbone-slave to AXI-master bridge.
package wb2axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    // Bookkeeping flags held by the bridge between transactions.
    typedef struct packed {
        logic dir_write;
        logic flush;
        logic err;
    } bridge_flags_t;

    // AXI SIZE encoding (log2 of bytes per beat) for a given data width.
    function automatic int size_of(input int dw);
        return $clog2(dw) - 3;
    endfunction

    // EXOKAY is deliberately treated as a plain success.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic result;
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:  result = 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: result = 1'b1;
            default:                          result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wbs2axim_bridge.sv
// Pipelined Wishbone B4 slave to AXI4 master: one single-beat AXI transaction per
// WB beat, in-order acks from an outstanding counter, with abort flush and error lockout.
module wbs2axim_bridge
    import wb2axi_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ID_WIDTH   = 2,
    parameter int LGDEPTH          = 4,
    localparam int LSBS = size_of(C_AXI_DATA_WIDTH),
    localparam int AW   = C_AXI_ADDR_WIDTH - LSBS,
    localparam int DW   = C_AXI_DATA_WIDTH,
    localparam int IW   = C_AXI_ID_WIDTH
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESET,

    input  logic                        i_wb_cyc,
    input  logic                        i_wb_stb,
    input  logic                        i_wb_we,
    input  logic [AW-1:0]               i_wb_addr,
    input  logic [DW-1:0]               i_wb_data,
    input  logic [DW/8-1:0]             i_wb_sel,
    output logic                        o_wb_stall,
    output logic                        o_wb_ack,
    output logic                        o_wb_err,
    output logic [DW-1:0]               o_wb_data,

    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [IW-1:0]               M_AXI_AWID,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]                  M_AXI_AWLEN,
    output logic [2:0]                  M_AXI_AWSIZE,
    output logic [1:0]                  M_AXI_AWBURST,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic [3:0]                  M_AXI_AWCACHE,

    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    output logic [DW-1:0]               M_AXI_WDATA,
    output logic [DW/8-1:0]             M_AXI_WSTRB,
    output logic                        M_AXI_WLAST,

    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    input  logic [IW-1:0]               M_AXI_BID,
    input  logic [1:0]                  M_AXI_BRESP,

    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    output logic [IW-1:0]               M_AXI_ARID,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic [3:0]                  M_AXI_ARCACHE,

    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY,
    input  logic [IW-1:0]               M_AXI_RID,
    input  logic [DW-1:0]               M_AXI_RDATA,
    input  logic                        M_AXI_RLAST,
    input  logic [1:0]                  M_AXI_RRESP
);

    localparam int            CW      = LGDEPTH + 1;
    localparam logic [CW-1:0] MAX_OUT = CW'(2 ** LGDEPTH);

    bridge_flags_t               flags;
    logic [CW-1:0]               outstanding;
    logic [CW-1:0]               outstanding_next;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_r;
    logic                        accept;
    logic                        b_hs;
    logic                        r_hs;
    logic                        resp_hs;
    logic                        resp_err;
    logic                        resp_pass;
    logic                        unused_inputs;

    assign unused_inputs = ^{M_AXI_BID, M_AXI_RID, M_AXI_RLAST};

    // Constant transaction attributes: single full-width INCR beats with ID 0.
    assign M_AXI_AWID    = '0;
    assign M_AXI_ARID    = '0;
    assign M_AXI_AWADDR  = addr_r;
    assign M_AXI_ARADDR  = addr_r;
    assign M_AXI_AWLEN   = '0;
    assign M_AXI_ARLEN   = '0;
    assign M_AXI_AWSIZE  = 3'(LSBS);
    assign M_AXI_ARSIZE  = 3'(LSBS);
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_AWCACHE = AXI_CACHE_DEFAULT;
    assign M_AXI_ARCACHE = AXI_CACHE_DEFAULT;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_BREADY  = !S_AXI_ARESET;
    assign M_AXI_RREADY  = !S_AXI_ARESET;

    always_comb begin
        o_wb_stall = 1'b0;
        if (!i_wb_cyc || flags.flush || flags.err)
            o_wb_stall = 1'b1;
        if ((M_AXI_AWVALID && !M_AXI_AWREADY) || (M_AXI_WVALID && !M_AXI_WREADY)
            || (M_AXI_ARVALID && !M_AXI_ARREADY))
            o_wb_stall = 1'b1;
        if (outstanding == MAX_OUT)
            o_wb_stall = 1'b1;
        if (outstanding != '0 && i_wb_we != flags.dir_write)
            o_wb_stall = 1'b1;
    end

    assign accept = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;
    assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;

    // Responses with nothing outstanding are stray and never reach the WB side.
    assign resp_hs   = (b_hs || r_hs) && (outstanding != '0);
    assign resp_err  = b_hs ? resp_is_err(M_AXI_BRESP) : resp_is_err(M_AXI_RRESP);
    assign resp_pass = resp_hs && i_wb_cyc && !flags.flush && !flags.err;

    always_comb begin
        outstanding_next = outstanding;
        case ({accept, resp_hs})
            2'b10:   outstanding_next = outstanding + 1'b1;
            2'b01:   outstanding_next = outstanding - 1'b1;
            default: outstanding_next = outstanding;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            outstanding <= '0;
            flags       <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (accept)
                flags.dir_write <= i_wb_we;
            // Flush lasts from an abandoned cycle until every in-flight response drains.
            if (outstanding_next == '0)
                flags.flush <= 1'b0;
            else if (!i_wb_cyc)
                flags.flush <= 1'b1;
            if (resp_pass && resp_err)
                flags.err <= 1'b1;
            else if (!i_wb_cyc && outstanding_next == '0)
                flags.err <= 1'b0;
        end
    end

    // AW and W retire independently; payload only changes on a fresh accept.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            addr_r        <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
        end else begin
            if (accept && i_wb_we)
                M_AXI_AWVALID <= 1'b1;
            else if (M_AXI_AWREADY)
                M_AXI_AWVALID <= 1'b0;
            if (accept && i_wb_we)
                M_AXI_WVALID <= 1'b1;
            else if (M_AXI_WREADY)
                M_AXI_WVALID <= 1'b0;
            if (accept && !i_wb_we)
                M_AXI_ARVALID <= 1'b1;
            else if (M_AXI_ARREADY)
                M_AXI_ARVALID <= 1'b0;
            if (accept) begin
                addr_r      <= C_AXI_ADDR_WIDTH'(i_wb_addr) << LSBS;
                M_AXI_WDATA <= i_wb_data;
                M_AXI_WSTRB <= i_wb_sel;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= resp_pass && !resp_err;
            o_wb_err <= resp_pass && resp_err;
            if (resp_pass && !resp_err && r_hs && !b_hs)
                o_wb_data <= M_AXI_RDATA;
        end
    end

endmodule
